sha256_sched_ctrl: RTL and testbench
====================================

# sha256_sched_ctrl

Block sequencer for the SHA-256 core. It buffers one 512-bit message block as 16 word-serial 32-bit writes, then drives the message-schedule unit (`ready`, `round_idx`, `M_next`) and the compression-round enable through 64 rounds. It also issues hash-init and hash-update strobes to the digest registers, and holds a digest handshake after the final block. It sits between the padded-message stream source and the schedule/compression datapath.

## Interface
- `NUM_ROUNDS`, 64, compression rounds per block; fixed at 64 for SHA-256.
- `NUM_WORDS`, 16, message words per block; fixed at 16.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `msg_valid`  in  1  message word valid.
- `msg_ready`  out  1  controller accepts a word; a transfer happens when `msg_valid` and `msg_ready` are both 1.
- `msg_word`  in  32  big-endian message word.
- `msg_last`  in  1  final-block flag; sampled only with word 15 of a block.
- `sched_ready`  out  1  schedule-unit enable; when 0, the schedule unit clears its window.
- `round_idx`  out  6  current round 0..63.
- `m_next`  out  32  message word for the schedule unit.
- `round_en`  out  1  compression-round enable.
- `hash_init`  out  1  one-cycle pulse: load IVs into H0..H7 and the working variables.
- `hash_update`  out  1  one-cycle pulse: H += working variables, reload the working variables.
- `digest_valid`  out  1  digest in H0..H7 is final.
- `digest_ready`  in  1  consumer accepts the digest.
- `busy`  out  1  1 in every state except LOAD with word count 0.

## Operation
- States: LOAD, RUN, UPDATE, DONE. All outputs except `m_next` are decoded from registered state. `m_next` is a mux of the buffer indexed by `round_idx`.
- Internal registers:
  - `buf[0:15]`, 16 x 32-bit word buffer.
  - `wcnt`, 4-bit write count.
  - `rcnt`, 6-bit round count.
  - `first`, 1 = next block starts a new message.
  - `last_q`, latched `msg_last`.
- LOAD:
  - `msg_ready`=1.
  - On each transfer: `buf[wcnt]` <= `msg_word`, `wcnt`++.
  - A transfer with `wcnt`==0 and `first`==1 asserts `hash_init` in that same cycle (combinational on the handshake) and clears `first`.
  - A transfer with `wcnt`==15 latches `last_q` <= `msg_last`, wraps `wcnt` to 0, clears `rcnt`, and moves to RUN.
  - `msg_last` on words 0..14 is ignored.
- RUN:
  - `msg_ready`=0, `sched_ready`=1, `round_en`=1, `round_idx`=`rcnt`.
  - `m_next`=`buf[rcnt]` when `rcnt`<16, else 0.
  - `rcnt`++ each cycle; at `rcnt`==63, move to UPDATE.
- UPDATE:
  - `hash_update`=1 for exactly one cycle; `sched_ready`=0 and `round_en`=0.
  - Next state is DONE if `last_q`=1, else LOAD.
- DONE:
  - `digest_valid`=1 and `msg_ready`=0.
  - When `digest_ready`=1, go to LOAD and set `first`=1.
- `round_idx` outputs 0 outside RUN.
- `rcnt` never exceeds 63.
- `wcnt` wraps only through the word-15 transfer.

## Timing
- Reset (cycle after `reset`=1 sampled): state=LOAD, `wcnt`=0, `rcnt`=0, `first`=1, `last_q`=0.
  - Outputs: `msg_ready`=1; `sched_ready`, `round_en`, `hash_init`, `hash_update`, `digest_valid`, `busy` all 0; `round_idx`=0; `m_next`=`buf[0]`.
  - The buffer is not cleared.
- Reset asserted mid-operation, in any state, aborts the block:
  - Returns to the reset state above next cycle.
  - Drops `sched_ready`, which clears the schedule window.
  - Discards any pending digest.
  - Reset has priority over handshakes in the same cycle.
- LOAD: 16 cycles minimum when `msg_valid` is held high; `msg_valid` gaps stall without limit.
- RUN: the edge accepting word 15 is followed by exactly 64 cycles with `round_idx`=0..63.
- UPDATE: one cycle directly after round 63.
- Minimum block period is 81 cycles (16+64+1).
- Latency from the word-15 transfer to `hash_update` is 65 cycles.
- DONE:
  - `digest_valid` first asserts the cycle after UPDATE and holds until sampled with `digest_ready`=1.
  - `digest_ready` already high on the first DONE cycle gives a one-cycle DONE.
  - The next message may begin transferring in the following cycle.
- `msg_valid` during RUN, UPDATE or DONE: no transfer, input ignored.

## Test plan
- Single block, message "abc" padded to 16 words, `msg_last`=1 on word 15:
  - `hash_init` pulses on the word-0 transfer.
  - `round_idx` counts 0..63 over 64 cycles; `m_next`=0x61626380 at `round_idx` 0.
  - `hash_update` pulses at +65 cycles.
  - `digest_valid` rises at +66; H = ba7816bf…f20015ad.
- Two-block message (56-byte NIST vector):
  - No `hash_init` on block 2.
  - Exactly two `hash_update` pulses and one `digest_valid`.
  - Digest 248d6a61…19db06c1.
- `msg_valid` toggled randomly during LOAD; `msg_valid`=1 held during RUN:
  - Buffer holds exactly the 16 handshaked words in order.
  - No extra transfers occur; `wcnt` wraps exactly once.
- `reset` pulsed at `round_idx`=30:
  - Next cycle state=LOAD, `sched_ready`=0, `round_en`=0, `msg_ready`=1, `first`=1.
  - A fresh "abc" block then yields the correct digest.
- `digest_ready` held low for 10 cycles in DONE:
  - `digest_valid` stays 1 and `msg_ready` stays 0.
  - On `digest_ready`=1, one cycle later `msg_ready`=1 and `digest_valid`=0.
- `msg_last`=1 on word 7 only, 0 on word 15: block treated as non-final; UPDATE goes to LOAD with no `digest_valid`.

Source files
------------

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 block sequencer: buffers one 16-word message block, then drives the
// schedule unit and compression rounds for 64 rounds, followed by a hash update.
module sha256_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS = 64,
    parameter int unsigned NUM_WORDS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_word,
    input  logic        msg_last,
    output logic        sched_ready,
    output logic [5:0]  round_idx,
    output logic [31:0] m_next,
    output logic        round_en,
    output logic        hash_init,
    output logic        hash_update,
    output logic        digest_valid,
    input  logic        digest_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        UPDATE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_WORD  = 4'(NUM_WORDS - 1);
    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_t      state;
    logic [31:0] msg_buf [NUM_WORDS];
    logic [3:0]  wcnt;
    logic [5:0]  rcnt;
    logic        first;
    logic        last_q;
    logic        xfer;

    // Reset wins over a handshake presented in the same cycle.
    assign xfer         = msg_valid && msg_ready && !reset;

    assign msg_ready    = (state == LOAD);
    assign sched_ready  = (state == RUN);
    assign round_en     = (state == RUN);
    assign hash_update  = (state == UPDATE);
    assign digest_valid = (state == DONE);
    assign busy         = !((state == LOAD) && (wcnt == '0));
    assign round_idx    = (state == RUN) ? rcnt : '0;
    assign hash_init    = xfer && (wcnt == '0) && first;

    // Rounds 16..63 take their words from the schedule recurrence, not the buffer.
    assign m_next = (round_idx < 6'(NUM_WORDS)) ? msg_buf[round_idx[3:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD;
            wcnt   <= '0;
            rcnt   <= '0;
            first  <= 1'b1;
            last_q <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        if (hash_init) begin
                            first <= 1'b0;
                        end
                        if (wcnt == LAST_WORD) begin
                            last_q <= msg_last;
                            wcnt   <= '0;
                            rcnt   <= '0;
                            state  <= RUN;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                end
                RUN: begin
                    if (rcnt == LAST_ROUND) begin
                        state <= UPDATE;
                    end else begin
                        rcnt <= rcnt + 6'd1;
                    end
                end
                UPDATE: begin
                    state <= last_q ? DONE : LOAD;
                end
                DONE: begin
                    if (digest_ready) begin
                        first <= 1'b1;
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // The word buffer is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            msg_buf[wcnt] <= msg_word;
        end
    end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Bench for sha256_sched_ctrl: a behavioural SHA-256 schedule/compression model
// consumes the controller's strobes so complete digests can be compared.
module tb_sha256_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_word;
    logic        msg_last;
    logic        sched_ready;
    logic [5:0]  round_idx;
    logic [31:0] m_next;
    logic        round_en;
    logic        hash_init;
    logic        hash_update;
    logic        digest_valid;
    logic        digest_ready;
    logic        busy;

    sha256_sched_ctrl #(
        .NUM_ROUNDS(64),
        .NUM_WORDS (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_word    (msg_word),
        .msg_last    (msg_last),
        .sched_ready (sched_ready),
        .round_idx   (round_idx),
        .m_next      (m_next),
        .round_en    (round_en),
        .hash_init   (hash_init),
        .hash_update (hash_update),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIGEST =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference datapath driven purely by the controller's strobes.
    logic [31:0] hreg [8];
    logic [31:0] wv   [8];
    logic [31:0] wsch [64];
    logic [31:0] t1, t2;
    int unsigned rt;
    int          init_cnt = 0;
    int          upd_cnt  = 0;
    int          dv_rise  = 0;
    int          xfer_cnt = 0;
    logic        dv_prev  = 1'b0;

    always @(negedge clk) begin
        if (msg_valid === 1'b1 && msg_ready === 1'b1 && reset === 1'b0) xfer_cnt++;
        if (digest_valid === 1'b1 && !dv_prev) dv_rise++;
        dv_prev = (digest_valid === 1'b1);
        if (hash_init === 1'b1) begin
            init_cnt++;
            for (int i = 0; i < 8; i++) begin
                hreg[i] = IV[i];
                wv[i]   = IV[i];
            end
        end else if (round_en === 1'b1) begin
            rt = int'(round_idx);
            if (rt < 16) wsch[rt] = m_next;
            else wsch[rt] = ssig1(wsch[rt-2]) + wsch[rt-7] + ssig0(wsch[rt-15]) + wsch[rt-16];
            t1 = wv[7] + bsig1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[rt] + wsch[rt];
            t2 = bsig0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
            wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
            wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
        end else if (hash_update === 1'b1) begin
            upd_cnt++;
            for (int i = 0; i < 8; i++) begin
                hreg[i] = hreg[i] + wv[i];
                wv[i]   = hreg[i];
            end
        end
    end

    function automatic logic [255:0] cur_digest();
        return {hreg[0], hreg[1], hreg[2], hreg[3], hreg[4], hreg[5], hreg[6], hreg[7]};
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic load_block(input logic [31:0] w [16], input logic last_at7,
                              input logic last_at15, input int unsigned gap_pct);
        int unsigned i = 0;
        int unsigned budget = 0;
        while (i < 16 && budget < 400) begin
            cyc();
            if ($urandom_range(99) < gap_pct) begin
                msg_valid = 1'b0;
                msg_word  = $urandom;
                msg_last  = 1'($urandom_range(1));
            end else begin
                msg_valid = 1'b1;
                msg_word  = w[i];
                msg_last  = (i == 7) ? last_at7 : ((i == 15) ? last_at15 : 1'b0);
            end
            smp();
            if (msg_valid && msg_ready) i++;
            budget++;
        end
        check("load_words", i, 16);
    endtask

    task automatic wait_update(output int unsigned n);
        n = 0;
        do begin
            cyc();
            smp();
            n++;
        end while (hash_update !== 1'b1 && n < 200);
        check("update_latency", n, 65);
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] word;
        logic        last;
        logic [5:0]  exp;  // {msg_ready, hash_init, busy, sched_ready, round_en, digest_valid}
    } vec_t;

    function automatic vec_t mkvec(input logic v, input logic [31:0] w, input logic l, input logic [2:0] e);
        vec_t r;
        r.valid = v;
        r.word  = w;
        r.last  = l;
        r.exp   = {e, 3'b000};
        return r;
    endfunction

    logic [31:0] abc_w [16];
    logic [31:0] blk1  [16];
    logic [31:0] blk2  [16];
    vec_t        tbl   [19];
    int          bad;
    int unsigned n;
    int          base_i, base_u, base_d, base_x;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; msg_valid = 1'b0; msg_last = 1'b0; msg_word = '0; digest_ready = 1'b0;

        for (int i = 0; i < 16; i++) begin
            abc_w[i] = '0;
            blk2[i]  = '0;
        end
        abc_w[0] = 32'h61626380; abc_w[15] = 32'h00000018;
        blk1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk2[15] = 32'h000001c0;

        // "abc" block with idle gaps; hash_init only on the word-0 transfer
        tbl[0] = mkvec(1'b0, 32'h0,     1'b0, 3'b100);
        tbl[1] = mkvec(1'b1, abc_w[0], 1'b0, 3'b110);
        tbl[2] = mkvec(1'b1, abc_w[1], 1'b1, 3'b101);
        tbl[3] = mkvec(1'b0, 32'h0,     1'b0, 3'b101);
        tbl[4] = mkvec(1'b0, 32'h0,     1'b1, 3'b101);
        for (int i = 2; i < 16; i++) tbl[i+3] = mkvec(1'b1, abc_w[i], (i == 15), 3'b101);

        cyc(); cyc(); smp();
        check("reset_outputs", {msg_ready, sched_ready, round_en, hash_init, hash_update, digest_valid, busy}, 7'b1000000);
        check("reset_round_idx", round_idx, 6'd0);
        cyc(); reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc();
            msg_valid = tbl[i].valid; msg_word = tbl[i].word; msg_last = tbl[i].last;
            smp();
            check($sformatf("load_vec%0d", i),
                  {msg_ready, hash_init, busy, sched_ready, round_en, digest_valid}, tbl[i].exp);
        end

        bad = 0;
        for (int k = 0; k < 64; k++) begin
            cyc();
            msg_valid = 1'b1; msg_word = 32'hdeadbeef; msg_last = 1'b1;
            smp();
            if (round_idx !== 6'(k) || sched_ready !== 1'b1 || round_en !== 1'b1 ||
                msg_ready !== 1'b0 || busy !== 1'b1 || hash_update !== 1'b0) bad++;
            if (k == 0)  check("m_next_r0", m_next, 32'h61626380);
            if (k == 15) check("m_next_r15", m_next, 32'h00000018);
            if (k == 16) check("m_next_r16", m_next, 32'h0);
        end
        check("run_rounds_bad", bad, 0);
        cyc(); smp();
        check("update_cycle", {hash_update, round_en, sched_ready, msg_ready, digest_valid}, 5'b10000);

        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(); smp();
            if (digest_valid !== 1'b1 || msg_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("done_hold_bad", bad, 0);
        check("abc_digest", cur_digest(), ABC_DIGEST);
        check("abc_xfers", xfer_cnt, 16);
        check("abc_counts", {init_cnt[7:0], upd_cnt[7:0], dv_rise[7:0]}, 24'h010101);
        cyc(); digest_ready = 1'b1; msg_valid = 1'b0; smp();
        check("done_accept_cycle", digest_valid, 1'b1);
        cyc(); digest_ready = 1'b0; smp();
        check("after_done", {msg_ready, digest_valid, busy}, 3'b100);

        // Two-block NIST message, consumer already ready for a one-cycle DONE
        base_i = init_cnt; base_u = upd_cnt; base_d = dv_rise; base_x = xfer_cnt;
        load_block(blk1, 1'b0, 1'b0, 30);
        wait_update(n);
        cyc(); msg_valid = 1'b0; smp();
        check("blk1_to_load", {msg_ready, digest_valid, busy}, 3'b100);
        load_block(blk2, 1'b0, 1'b1, 30);
        digest_ready = 1'b1;
        n = 0;
        do begin cyc(); smp(); n++; end while (digest_valid !== 1'b1 && n < 200);
        check("blk2_dv_latency", n, 66);
        check("two_block_digest", cur_digest(), TWO_DIGEST);
        cyc(); msg_valid = 1'b0; smp();
        check("one_cycle_done", {msg_ready, digest_valid}, 2'b10);
        digest_ready = 1'b0;
        check("two_block_counts", {8'(init_cnt - base_i), 8'(upd_cnt - base_u), 8'(dv_rise - base_d)}, 24'h010201);
        check("two_block_xfers", xfer_cnt - base_x, 32);

        // Reset at round 30 with a handshake offered in the same cycle
        load_block(abc_w, 1'b0, 1'b1, 20);
        n = 0;
        do begin cyc(); smp(); n++; end while (round_idx !== 6'd30 && n < 100);
        check("reached_r30", round_idx, 6'd30);
        reset = 1'b1; msg_valid = 1'b1;
        cyc(); smp();
        check("reset_mid_run", {msg_ready, sched_ready, round_en, hash_init, hash_update, digest_valid, busy}, 7'b1000000);
        check("reset_mid_round_idx", round_idx, 6'd0);
        cyc(); reset = 1'b0; msg_valid = 1'b0;
        base_i = init_cnt;
        load_block(abc_w, 1'b0, 1'b1, 20);
        n = 0;
        do begin cyc(); smp(); n++; end while (digest_valid !== 1'b1 && n < 200);
        check("after_reset_digest", cur_digest(), ABC_DIGEST);
        check("after_reset_init", init_cnt - base_i, 1);
        cyc(); digest_ready = 1'b1; msg_valid = 1'b0; smp();
        cyc(); digest_ready = 1'b0; smp();

        // msg_last on word 7 only: block must not be treated as final
        base_d = dv_rise;
        load_block(abc_w, 1'b1, 1'b0, 20);
        wait_update(n);
        cyc(); msg_valid = 1'b0; smp();
        check("nonfinal_to_load", {msg_ready, digest_valid, busy}, 3'b100);
        cyc(); smp();
        check("nonfinal_no_digest", dv_rise - base_d, 0);

        // Reset while a digest is pending discards it
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        load_block(abc_w, 1'b0, 1'b1, 0);
        n = 0;
        do begin cyc(); smp(); n++; end while (digest_valid !== 1'b1 && n < 200);
        check("pending_digest", cur_digest(), ABC_DIGEST);
        reset = 1'b1;
        cyc(); smp();
        check("reset_in_done", {digest_valid, msg_ready, busy}, 3'b010);
        cyc(); reset = 1'b0; msg_valid = 1'b0; smp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
